// File: rtl/axi_lite_ram_if.sv
// Memory-bus bundle between the riscv core (master) and axi_lite_ram (slave).
// Note that bvalid is driven by the core and bready by the RAM.
interface axi_lite_ram_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddress;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddress;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddress, awprot, wvalid, wdata, wstrb, bvalid,
             arvalid, araddress, arprot, rready,
      input  awready, wready, bready, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddress, awprot, wvalid, wdata, wstrb, bvalid,
             arvalid, araddress, arprot, rready,
      output awready, wready, bready, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_ram.sv
// Word-addressed AXI-Lite-style responder RAM with independent write and read FSMs.
// Optional access protection is enabled by defining AXI_RAM_PROT_EN.
module axi_lite_ram #(
   parameter int          DEPTH = 1024,
   parameter logic [31:0] BASE  = 32'h0000_0000
) (
   input logic           clk,
   input logic           reset,
   axi_lite_ram_if.slave bus
);
   localparam int          IW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_DATA}            rd_state_t;

   logic [31:0] mem [DEPTH];

   wr_state_t   wr_state;
   logic        aw_done, w_done;
   logic [31:0] aw_addr;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   rd_state_t   rd_state;

   logic [31:0] wr_off, rd_off;
   logic [IW-1:0] wr_idx, rd_idx;
   logic        wr_hit, rd_hit, wr_slverr, rd_slverr;
   logic        wr_commit, mem_we;

   assign wr_off = aw_addr - BASE;
   assign rd_off = bus.araddress - BASE;
   assign wr_idx = wr_off[IW+1:2];
   assign rd_idx = rd_off[IW+1:2];
   assign wr_hit = wr_off < SPAN;
   assign rd_hit = rd_off < SPAN;

`ifdef AXI_RAM_PROT_EN
   logic aw_instr;
   logic unused_prot;
   assign wr_slverr   = aw_instr;
   assign rd_slverr   = !bus.arprot[0] && (rd_off < 32'd64);
   assign unused_prot = &{1'b0, bus.awprot[1:0], bus.arprot[2:1]};
`else
   logic unused_prot;
   assign wr_slverr   = 1'b0;
   assign rd_slverr   = 1'b0;
   assign unused_prot = &{1'b0, bus.awprot, bus.arprot};
`endif

   logic unused_addr;
   assign unused_addr = &{1'b0, wr_off[1:0], rd_off[1:0], wr_off[31:IW+2], rd_off[31:IW+2]};

   // Commit happens in the cycle after both halves of the write are held.
   assign wr_commit = (wr_state == W_COLLECT) && aw_done && w_done;
   assign mem_we    = wr_commit && wr_hit && !wr_slverr;

   // NOTE: the storage array has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) mem[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; that also makes a
   // same-cycle read of a word being written return its old contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_state    <= W_IDLE;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         aw_addr     <= '0;
         w_data      <= '0;
         w_strb      <= '0;
         bus.awready <= 1'b0;
         bus.wready  <= 1'b0;
         bus.bready  <= 1'b0;
         bus.bresp   <= RESP_OKAY;
`ifdef AXI_RAM_PROT_EN
         aw_instr    <= 1'b0;
`endif
      end else begin
         case (wr_state)
            W_IDLE, W_COLLECT: begin
               if (wr_commit) begin
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
                  bus.bready <= 1'b1;
                  bus.bresp  <= !wr_hit   ? RESP_DECERR :
                                wr_slverr ? RESP_SLVERR : RESP_OKAY;
                  wr_state   <= W_RESP;
               end else begin
                  if (bus.awvalid && bus.awready) begin
                     aw_addr     <= bus.awaddress;
`ifdef AXI_RAM_PROT_EN
                     aw_instr    <= bus.awprot[2];
`endif
                     aw_done     <= 1'b1;
                     bus.awready <= 1'b0;
                  end else if (!aw_done) begin
                     bus.awready <= 1'b1;
                  end
                  if (bus.wvalid && bus.wready) begin
                     w_data     <= bus.wdata;
                     w_strb     <= bus.wstrb;
                     w_done     <= 1'b1;
                     bus.wready <= 1'b0;
                  end else if (!w_done) begin
                     bus.wready <= 1'b1;
                  end
                  if (aw_done || w_done || (bus.awvalid && bus.awready) ||
                      (bus.wvalid && bus.wready))
                     wr_state <= W_COLLECT;
                  else
                     wr_state <= W_IDLE;
               end
            end
            W_RESP: begin
               if (bus.bvalid) begin
                  bus.bready  <= 1'b0;
                  bus.awready <= 1'b1;
                  bus.wready  <= 1'b1;
                  wr_state    <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state    <= R_IDLE;
         bus.arready <= 1'b0;
         bus.rvalid  <= 1'b0;
         bus.rdata   <= '0;
         bus.rresp   <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (bus.arvalid && bus.arready) begin
                  bus.arready <= 1'b0;
                  bus.rvalid  <= 1'b1;
                  bus.rdata   <= (rd_hit && !rd_slverr) ? mem[rd_idx] : 32'h0;
                  bus.rresp   <= !rd_hit   ? RESP_DECERR :
                                 rd_slverr ? RESP_SLVERR : RESP_OKAY;
                  rd_state    <= R_DATA;
               end else begin
                  bus.arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  bus.rvalid  <= 1'b0;
                  bus.arready <= 1'b1;
                  rd_state    <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed self-checking bench for axi_lite_ram (default DEPTH=1024, BASE=0).
// Expectations for the protection steps follow AXI_RAM_PROT_EN.
module tb_axi_lite_ram;
   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   axi_lite_ram_if bus ();

   axi_lite_ram dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef AXI_RAM_PROT_EN
   localparam logic [1:0]  EXP_PROT_BRESP = 2'b10;
   localparam logic [31:0] EXP_PROT_WORD  = 32'h1122_3344;
   localparam logic [1:0]  EXP_PROT_RRESP = 2'b10;
   localparam logic [31:0] EXP_PROT_RDATA = 32'h0000_0000;
`else
   localparam logic [1:0]  EXP_PROT_BRESP = 2'b00;
   localparam logic [31:0] EXP_PROT_WORD  = 32'h0BAD_F00D;
   localparam logic [1:0]  EXP_PROT_RRESP = 2'b00;
   localparam logic [31:0] EXP_PROT_RDATA = 32'h1234_5678;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot,
                           output logic [1:0] resp);
      int n;
      bus.awvalid   = 1'b1;
      bus.awaddress = addr;
      bus.awprot    = prot;
      bus.wvalid    = 1'b1;
      bus.wdata     = data;
      bus.wstrb     = strb;
      bus.bvalid    = 1'b1;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      n = 0;
      while (bus.bready !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      check("wr_bready_seen", bus.bready, 1);
      resp = bus.bresp;
      step();
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [2:0] prot,
                          output logic [31:0] data, output logic [1:0] resp);
      int n;
      bus.arvalid   = 1'b1;
      bus.araddress = addr;
      bus.arprot    = prot;
      bus.rready    = 1'b1;
      step();
      bus.arvalid = 1'b0;
      n = 0;
      while (bus.rvalid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      check("rd_rvalid_seen", bus.rvalid, 1);
      data = bus.rdata;
      resp = bus.rresp;
      step();
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;

      reset         = 1'b1;
      bus.awvalid   = 1'b0;
      bus.awaddress = '0;
      bus.awprot    = '0;
      bus.wvalid    = 1'b0;
      bus.wdata     = '0;
      bus.wstrb     = '0;
      bus.bvalid    = 1'b0;
      bus.arvalid   = 1'b0;
      bus.araddress = '0;
      bus.arprot    = 3'b001;
      bus.rready    = 1'b1;

      // Reset held for three cycles.
      repeat (3) step();
      check("rst_awready", bus.awready, 0);
      check("rst_wready",  bus.wready,  0);
      check("rst_arready", bus.arready, 0);
      check("rst_bready",  bus.bready,  0);
      check("rst_rvalid",  bus.rvalid,  0);
      check("rst_bresp",   bus.bresp,   0);
      check("rst_rresp",   bus.rresp,   0);
      check("rst_rdata",   bus.rdata,   0);
      reset = 1'b0;
      step();
      check("post_rst_awready", bus.awready, 1);
      check("post_rst_wready",  bus.wready,  1);
      check("post_rst_arready", bus.arready, 1);

      // Full write, address and data together, with cycle-exact timing.
      bus.awvalid   = 1'b1;
      bus.awaddress = 32'h8;
      bus.awprot    = 3'b000;
      bus.wvalid    = 1'b1;
      bus.wdata     = 32'hDEAD_BEEF;
      bus.wstrb     = 4'hF;
      bus.bvalid    = 1'b1;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check("w1_accept_awready", bus.awready, 0);
      check("w1_accept_wready",  bus.wready,  0);
      check("w1_accept_bready",  bus.bready,  0);
      step();
      check("w1_bready", bus.bready, 1);
      check("w1_bresp",  bus.bresp,  0);
      step();
      check("w1_retire_bready",  bus.bready,  0);
      check("w1_retire_awready", bus.awready, 1);
      check("w1_retire_wready",  bus.wready,  1);

      do_read(32'h8, 3'b001, d, r);
      check("r1_rdata", d, 32'hDEAD_BEEF);
      check("r1_rresp", r, 0);

      // Data presented two cycles ahead of the address, single byte strobe.
      bus.wvalid = 1'b1;
      bus.wdata  = 32'h0000_5500;
      bus.wstrb  = 4'b0010;
      bus.bvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      check("strb_wready_low",   bus.wready,  0);
      check("strb_awready_high", bus.awready, 1);
      step();
      bus.awvalid   = 1'b1;
      bus.awaddress = 32'h8;
      step();
      bus.awvalid = 1'b0;
      check("strb_wait_bready", bus.bready, 0);
      step();
      check("strb_bready", bus.bready, 1);
      check("strb_bresp",  bus.bresp,  0);
      step();
      do_read(32'h8, 3'b001, d, r);
      check("strb_rdata", d, 32'hDEAD_55EF);

      // Read backpressure: rready low for five cycles.
      bus.arvalid   = 1'b1;
      bus.araddress = 32'h8;
      bus.rready    = 1'b0;
      step();
      bus.arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rbp_rvalid",  bus.rvalid,  1);
         check("rbp_rdata",   bus.rdata,   32'hDEAD_55EF);
         check("rbp_arready", bus.arready, 0);
         step();
      end
      bus.rready = 1'b1;
      step();
      check("rbp_retire_rvalid",  bus.rvalid,  0);
      check("rbp_retire_arready", bus.arready, 1);

      // Write backpressure: bvalid low holds the response.
      bus.bvalid    = 1'b0;
      bus.awvalid   = 1'b1;
      bus.awaddress = 32'hC;
      bus.wvalid    = 1'b1;
      bus.wdata     = 32'h1122_3344;
      bus.wstrb     = 4'hF;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         check("wbp_bready",  bus.bready,  1);
         check("wbp_awready", bus.awready, 0);
         check("wbp_wready",  bus.wready,  0);
         step();
      end
      bus.bvalid = 1'b1;
      step();
      check("wbp_retire_bready",  bus.bready,  0);
      check("wbp_retire_awready", bus.awready, 1);
      do_read(32'hC, 3'b001, d, r);
      check("wbp_rdata", d, 32'h1122_3344);

      // wstrb of zero is a legal no-op.
      do_write(32'h8, 32'hFFFF_FFFF, 4'h0, 3'b000, r);
      check("nostrb_bresp", r, 0);
      do_read(32'h8, 3'b001, d, r);
      check("nostrb_rdata", d, 32'hDEAD_55EF);

      // Read and write commit to the same word in one cycle.
      bus.awvalid   = 1'b1;
      bus.awaddress = 32'h8;
      bus.wvalid    = 1'b1;
      bus.wdata     = 32'h1234_5678;
      bus.wstrb     = 4'hF;
      bus.bvalid    = 1'b1;
      step();
      bus.awvalid   = 1'b0;
      bus.wvalid    = 1'b0;
      bus.arvalid   = 1'b1;
      bus.araddress = 32'h8;
      bus.arprot    = 3'b001;
      bus.rready    = 1'b0;
      step();
      bus.arvalid = 1'b0;
      check("rbw_bready", bus.bready, 1);
      check("rbw_rvalid", bus.rvalid, 1);
      check("rbw_rdata",  bus.rdata,  32'hDEAD_55EF);
      bus.rready = 1'b1;
      step();
      do_read(32'h8, 3'b001, d, r);
      check("rbw_new_rdata", d, 32'h1234_5678);

      // Decode error one past the end; word 0 must not alias.
      do_write(32'h0, 32'hA5A5_A5A5, 4'hF, 3'b000, r);
      check("dec_w0_bresp", r, 0);
      do_write(32'h1000, 32'hFFFF_FFFF, 4'hF, 3'b000, r);
      check("dec_bresp", r, 2'b11);
      do_write(32'h1000, 32'hFFFF_FFFF, 4'hF, 3'b100, r);
      check("dec_prec_bresp", r, 2'b11);
      do_read(32'h1000, 3'b001, d, r);
      check("dec_rresp", r, 2'b11);
      check("dec_rdata", d, 0);
      do_read(32'h0, 3'b001, d, r);
      check("dec_w0_intact", d, 32'hA5A5_A5A5);

      // Protection attributes.
      do_write(32'hC, 32'h0BAD_F00D, 4'hF, 3'b100, r);
      check("prot_bresp", r, EXP_PROT_BRESP);
      do_read(32'hC, 3'b001, d, r);
      check("prot_word", d, EXP_PROT_WORD);
      do_read(32'h8, 3'b000, d, r);
      check("prot_rresp", r, EXP_PROT_RRESP);
      check("prot_rdata", d, EXP_PROT_RDATA);
      do_read(32'h40, 3'b000, d, r);
      check("prot_high_rresp", r, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_lite_ram.md
# axi_lite_ram

Single-port word-addressed AXI-Lite-style responder RAM that sits on the other end of the `riscv` core's memory bus. It answers the core's write-address, write-data, write-response, read-address and read-data channels, and uses the same channel signal names as the core. It serves as the instruction/data backing store for simulation and FPGA builds, and as the bus peer for whole-system formal runs.

## Interface
Parameters:
- `DEPTH`, 1024: RAM size in 32-bit words; must be a power of two.
- `BASE`, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH*4.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `awvalid`  in  1  initiator presents write address.
- `awready`  out  1  block accepts write address.
- `awaddress`  in  32  write byte address.
- `awprot`  in  3  write permissions.
- `wvalid`  in  1  initiator presents write data.
- `wready`  out  1  block accepts write data.
- `wdata`  in  32  write data.
- `wstrb`  in  4  byte enables; bit i enables `wdata[8i+7:8i]`.
- `bvalid`  in  1  initiator takes the write response (core-driven).
- `bready`  out  1  write response is available.
- `bresp`  out  2  write status.
- `arvalid`  in  1  initiator presents read address.
- `arready`  out  1  block accepts read address.
- `araddress`  in  32  read byte address.
- `arprot`  in  3  read permissions.
- `rvalid`  out  1  read data is valid.
- `rready`  in  1  initiator takes the read data.
- `rdata`  out  32  read data.
- `rresp`  out  2  read status.

## Operation
- The write path and the read path are independent FSMs. They share only the storage array.
- Write FSM states: IDLE, COLLECT, RESP.
  - IDLE/COLLECT: `awready` stays high until the address is captured. `wready` stays high until the data is captured.
  - Address and data may be captured in either order or in the same cycle. The captured side deasserts its ready.
  - Once both are captured, the FSM commits. It writes the enabled bytes (a response of OKAY only), asserts `bready`, drives `bresp`, and enters RESP.
  - RESP: `bready` and `bresp` are held until `bvalid`=1. The FSM then returns to IDLE. `awready` and `wready` reassert the next cycle.
- Read FSM states: IDLE, DATA.
  - IDLE: `arready`=1. On `arvalid`, the array is read and the FSM enters DATA.
  - DATA: `rvalid`=1, and `rdata`/`rresp` are held stable until `rready`=1. The FSM then returns to IDLE and `arready` reasserts the next cycle.
- Address decode uses the address minus `BASE`, taking word index = bits [log2(DEPTH)+1:2]. Low two address bits are ignored.
- Response codes:
  - OKAY = 2'b00.
  - DECERR = 2'b11 when the address is outside [BASE, BASE+DEPTH*4). The write is dropped, and an error read returns `rdata`=0.
  - SLVERR = 2'b10 per Configuration.
- `wstrb`=0 is a legal no-op write and responds OKAY.

## Timing
- While `reset` is high, and asynchronously on its assertion: `awready`, `wready`, `arready`, `bready` and `rvalid` = 0; `bresp`, `rresp` = 0; `rdata` = 0. Both FSMs go to IDLE. RAM contents are not reset.
- The first posedge after `reset` is released sets `awready`, `wready` and `arready` to 1.
- Write latency: `bready` rises on the first posedge after the cycle in which both address and data have been captured.
- Read latency: `rvalid` rises on the posedge after the `arvalid`&&`arready` cycle.
- Minimum cycles per transaction:
  - Write: 3 cycles (accept, respond, retire).
  - Read: 2 cycles (accept, data+retire).
- A read and a write commit to the same word in the same cycle: the read returns the old data (read-before-write).
- Reset asserted mid-transaction aborts the transaction. A partially collected write is never committed.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `AXI_RAM_PROT_EN`.
- When defined:
  - A write with `awprot[2]`=1 (instruction access) is not committed and responds SLVERR.
  - A read with `arprot[0]`=0 (unprivileged) to the lowest 64 bytes responds SLVERR with `rdata`=0.
  - DECERR takes precedence over SLVERR.
- When undefined: `awprot` and `arprot` are ignored and these responses are always OKAY.

## Test plan
- Reset then idle: hold `reset`=1 for 3 cycles → all readys, `bready` and `rvalid` are 0. Release `reset` → `awready`, `wready` and `arready` are 1 on the next edge.
- Full write then read: write 0xDEADBEEF at BASE+8 with `wstrb`=4'hF, address and data in the same cycle, `bvalid`=1 → `bready` with `bresp`=00 two edges later. Then read BASE+8 → `rdata`=0xDEADBEEF, `rresp`=00.
- Byte strobes and ordering: `wdata` is presented 2 cycles before `awvalid`, with `wstrb`=4'b0010, data 0x0000_5500, over 0xDEADBEEF → readback 0xDEAD55EF.
- Backpressure: hold `rready`=0 for 5 cycles → `rvalid` and `rdata` stay stable and `arready`=0. Hold `bvalid`=0 → `bready`, `awready`=0 and `wready`=0 are held.
- Decode error: write and read at BASE+DEPTH*4 → `bresp`=11, `rresp`=11, `rdata`=0. No word changes.
- Protection, macro defined: write with `awprot`=3'b100 → `bresp`=10 and memory unchanged. With the macro undefined, the same write → `bresp`=00 and memory is updated.
